flujo_adc_sampler: RTL
======================

Name: flujo_adc_sampler

Overview:
Upstream stage of the spirometer flow path. It periodically reads an 8-bit serial ADC that digitises the flow sensor, averages the last 2^AVG_LOG2 samples, and forces values inside a noise deadband to zero. It delivers the 8-bit flow value plus a one-cycle strobe. The flow and strobe feed the loser/no-flow detector's flow input and clock-enable directly.

Parameters:
CLK_DIV, 50, iClk cycles per SCLK half-period (>=1)
SAMPLE_PERIOD, 100000, iClk cycles between conversion starts; must be >= 18*CLK_DIV+4
AVG_LOG2, 2, log2 of moving-average depth (1..4)
DEADBAND, 8'd4, averaged values <= DEADBAND are output as 0

Ports:
iClk  in  1  system clock, single clock domain
iReset  in  1  reset; one clock; reset is synchronous and active-low
iEnable  in  1  1 = periodic sampling active
iAdcDout  in  1  ADC serial data, MSB first
oAdcCs_n  out  1  ADC chip select, active low
oAdcSclk  out  1  ADC serial clock
ovFlujo  out  8  filtered flow value
oCe  out  1  one-cycle strobe; ovFlujo is updated in the same cycle
oBusy  out  1  high from CS fall until oCe

Behaviour:
- Reset (iReset==0 at posedge): oAdcCs_n=1, oAdcSclk=0, ovFlujo=0, oCe=0, oBusy=0, FSM=IDLE. Period counter, average buffer and sum all clear to 0. Reset applies the same way mid-conversion; no partial result is emitted.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps while iEnable=1. It is held at 0 while iEnable=0. A tick is the wrap.
  - Tick in IDLE starts a conversion.
  - Tick in any other state is dropped, not queued.
- FSM states:
  - IDLE: on tick, go to START; drive oAdcCs_n=0 and oBusy=1.
  - START: one full SCLK period (low CLK_DIV cycles, then high CLK_DIV cycles). This is the ADC start/mux cycle; no capture.
  - SHIFT: 8 SCLK periods. iAdcDout is captured into the shift register on the iClk cycle where SCLK goes 0->1, MSB first. After the 8th high half-period, SCLK returns low, oAdcCs_n=1, go to AVG.
  - AVG (1 cycle):
    - sum <= sum - buf[wr_ptr] + new_sample; buf[wr_ptr] <= new_sample; wr_ptr wraps modulo 2^AVG_LOG2.
    - sum width is 8+AVG_LOG2, so it cannot overflow.
  - OUT (1 cycle):
    - avg = sum >> AVG_LOG2, truncated.
    - ovFlujo <= (avg <= DEADBAND) ? 0 : avg.
    - oCe=1, oBusy=0, then go to IDLE.
- Latency: the oCe cycle is exactly 18*CLK_DIV+2 iClk cycles after the cycle oAdcCs_n falls.
- ovFlujo holds its value between strobes. oCe is never high two cycles in a row.
- Warm-up: the buffer starts at zero, so the first 2^AVG_LOG2-1 outputs ramp up. This is intended.
- iEnable falling mid-conversion: the current conversion completes and emits oCe, then no new CS fall occurs. iEnable rising restarts the counter from 0.
- SCLK idles low whenever CS is high.

Optional Feature:
FLUJO_PEAK_HOLD_EN
- Defined: adds input iClearPeak (1 bit) and output ovPico (8 bits).
  - ovPico <= max(ovFlujo) over every OUT cycle; value after reset is 0.
  - iClearPeak=1 sets ovPico to 0 next cycle.
  - If iClearPeak and OUT coincide, ovPico takes the new ovFlujo.
- Undefined: these ports and their logic are absent; the rest of the block behaves identically.

Decomposition:
- Shared package flujo_pkg: FLUJO_W=8 constant and the FSM state enum (IDLE, START, SHIFT, AVG, OUT).
- One sub-module, adc_serial_rx: owns CS/SCLK generation, the bit counter and the shift register. It takes a start pulse and returns sample[7:0] with a done pulse.
- Averaging, deadband and output registers stay in the top.

Test Plan:
Bench parameters: CLK_DIV=2, SAMPLE_PERIOD=64, AVG_LOG2=2, DEADBAND=4, with a behavioural ADC model.
1. Hold iReset=0 for 3 cycles -> oAdcCs_n=1, oAdcSclk=0, ovFlujo=0, oCe=0, oBusy=0; no CS fall while reset is held.
2. ADC constant 0xA5, iEnable=1:
   - outputs 0x29, 0x52, 0x7B, 0xA5, 0xA5;
   - oCe is one cycle wide, strobes are 64 cycles apart, and CS fall to oCe is 38 cycles.
3. ADC constant 0x10 from reset -> outputs 0x00 (avg 4 is in the deadband), then 0x08, 0x0C, 0x10.
4. Steady 0x80, then ADC switches to 0x00 -> outputs 0x60, 0x40, 0x20, 0x00, 0x00… (this is the zero-flow sequence consumed downstream).
5. iEnable dropped during SHIFT -> exactly one more oCe with the correct value; oAdcCs_n stays 1 for the next 200 cycles.
6. iReset=0 pulsed during SHIFT -> next cycle CS=1, SCLK=0, ovFlujo=0. After release with ADC 0xFF, the first output is 0x3F.

Source files
------------

// File: rtl/flujo_pkg.sv
// Shared types for the spirometer flow sampler: data width and sequencing states.
package flujo_pkg;

    localparam int FLUJO_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        AVG,
        OUT
    } flujo_state_e;

    function automatic logic [FLUJO_W-1:0] max_flujo(input logic [FLUJO_W-1:0] a,
                                                     input logic [FLUJO_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flujo_adc_sampler_if.sv
// Pins of the serial flow ADC plus the filtered flow stream delivered downstream.
interface flujo_adc_sampler_if;
    import flujo_pkg::*;

    logic                 iAdcDout;
    logic                 oAdcCs_n;
    logic                 oAdcSclk;
    logic [FLUJO_W-1:0]   ovFlujo;
    logic                 oCe;
    logic                 oBusy;

    modport master (
        input  iAdcDout,
        output oAdcCs_n,
        output oAdcSclk,
        output ovFlujo,
        output oCe,
        output oBusy
    );

    modport slave (
        output iAdcDout,
        input  oAdcCs_n,
        input  oAdcSclk,
        input  ovFlujo,
        input  oCe,
        input  oBusy
    );

endinterface

// File: rtl/adc_serial_rx.sv
// Serial ADC front end: CS/SCLK generation, one start/mux SCLK period, then eight
// MSB-first data bits captured on the SCLK rising transition.
module adc_serial_rx
    import flujo_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               adc_dout,
    output logic               cs_n,
    output logic               sclk,
    output logic               mux_done,
    output logic               done,
    output logic [FLUJO_W-1:0] sample
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam int HALVES = 2 * (FLUJO_W + 1);

    logic               active;
    logic [DW-1:0]      div_cnt;
    logic [4:0]         half_cnt;
    logic [FLUJO_W-1:0] shreg;
    logic               half_end;

    // half_cnt holds the number of half-periods still to come after the current one
    assign half_end = active && (div_cnt == '0);
    assign mux_done = half_end && (half_cnt == 5'(HALVES - 2));
    assign done     = half_end && (half_cnt == '0);
    assign sample   = shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
        end else if (start && !active) begin
            active   <= 1'b1;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            div_cnt  <= DIV_LAST;
            half_cnt <= 5'(HALVES - 1);
        end else if (active) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - DW'(1);
            end else if (half_cnt == '0) begin
                active <= 1'b0;
                cs_n   <= 1'b1;
                sclk   <= 1'b0;
            end else begin
                sclk     <= ~sclk;
                half_cnt <= half_cnt - 5'd1;
                div_cnt  <= DIV_LAST;
                // rising edges after the start/mux period carry data
                if (!sclk && (half_cnt <= 5'(HALVES - 3))) begin
                    shreg <= {shreg[FLUJO_W-2:0], adc_dout};
                end
            end
        end
    end

endmodule

// File: rtl/flujo_adc_sampler.sv
// Periodic flow ADC sampler with moving average and noise deadband.
// Optional peak hold output is built when FLUJO_PEAK_HOLD_EN is defined.
//
// state | meaning
// IDLE  | waiting for the sample-period tick
// START | CS low, ADC start/mux SCLK period
// SHIFT | eight data SCLK periods
// AVG   | fold new sample into the running sum
// OUT   | publish filtered value and strobe
module flujo_adc_sampler
    import flujo_pkg::*;
#(
    parameter int                 CLK_DIV       = 50,
    parameter int                 SAMPLE_PERIOD = 100000,
    parameter int                 AVG_LOG2      = 2,
    parameter logic [FLUJO_W-1:0] DEADBAND      = 8'd4
) (
    input  logic                   iClk,
    input  logic                   iReset,
    input  logic                   iEnable,
    flujo_adc_sampler_if.master    bus
`ifdef FLUJO_PEAK_HOLD_EN
    ,
    input  logic                   iClearPeak,
    output logic [FLUJO_W-1:0]     ovPico
`endif
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = FLUJO_W + AVG_LOG2;
    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] PER_LAST = CW'(SAMPLE_PERIOD - 1);

    flujo_state_e       state_q, state_d;
    logic [CW-1:0]      per_cnt;
    logic               tick;
    logic               start;
    logic               mux_done;
    logic               rx_done;
    logic [FLUJO_W-1:0] sample;
    logic [FLUJO_W-1:0] avg;
    logic [FLUJO_W-1:0] filt;
    logic [SW-1:0]      sum_q;
    logic [FLUJO_W-1:0] sample_buf [N];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [FLUJO_W-1:0] flujo_q;
    logic               ce_q;
    logic               busy_q;

    assign tick = iEnable && (per_cnt == PER_LAST);

    always_ff @(posedge iClk) begin
        if (!iReset || !iEnable) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + CW'(1);
        end
    end

    adc_serial_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk      (iClk),
        .rst_n    (iReset),
        .start    (start),
        .adc_dout (bus.iAdcDout),
        .cs_n     (bus.oAdcCs_n),
        .sclk     (bus.oAdcSclk),
        .mux_done (mux_done),
        .done     (rx_done),
        .sample   (sample)
    );

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    start   = 1'b1;
                    state_d = START;
                end
            end
            START:   if (mux_done) state_d = SHIFT;
            SHIFT:   if (rx_done)  state_d = AVG;
            AVG:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign avg  = sum_q[SW-1:AVG_LOG2];
    assign filt = (avg <= DEADBAND) ? '0 : avg;

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            sum_q   <= '0;
            wr_ptr  <= '0;
            flujo_q <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sample_buf[i] <= '0;
            end
        end else begin
            ce_q <= 1'b0;
            case (state_q)
                IDLE: if (start) busy_q <= 1'b1;
                AVG: begin
                    // oldest sample leaves the window as the new one enters
                    sum_q              <= sum_q - SW'(sample_buf[wr_ptr]) + SW'(sample);
                    sample_buf[wr_ptr] <= sample;
                    wr_ptr             <= wr_ptr + AVG_LOG2'(1);
                end
                OUT: begin
                    flujo_q <= filt;
                    ce_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ovFlujo = flujo_q;
    assign bus.oCe     = ce_q;
    assign bus.oBusy   = busy_q;

`ifdef FLUJO_PEAK_HOLD_EN
    logic [FLUJO_W-1:0] pico_q;

    // a clear coinciding with a new output restarts the peak at that output
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            pico_q <= '0;
        end else if (state_q == OUT) begin
            pico_q <= iClearPeak ? filt : max_flujo(pico_q, filt);
        end else if (iClearPeak) begin
            pico_q <= '0;
        end
    end

    assign ovPico = pico_q;
`endif

endmodule
